// File: rtl/vdf_stage_if.sv
// EX-side operand bus of the vector data fetch stage: one operand pair per valid/ready transfer.
// The stage drives it through the master modport and EX consumes it through the slave modport.
interface vdf_stage_if #(
    parameter int ELEM_W  = 32,
    parameter int VREG_AW = 3,
    parameter int IDX_W   = 3
);
    logic               ex_valid;
    logic               ex_ready;
    logic [ELEM_W-1:0]  ex_vs_val;
    logic [ELEM_W-1:0]  ex_vt_val;
    logic [VREG_AW-1:0] ex_vd_add;
    logic [IDX_W-1:0]   ex_idx;
    logic [5:0]         ex_op;
    logic [5:0]         ex_func;
    logic [4:0]         ex_shamt;
    logic [15:0]        ex_imm16;
    logic               ex_last;

    modport master (
        output ex_valid, ex_vs_val, ex_vt_val, ex_vd_add, ex_idx,
               ex_op, ex_func, ex_shamt, ex_imm16, ex_last,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_vs_val, ex_vt_val, ex_vd_add, ex_idx,
               ex_op, ex_func, ex_shamt, ex_imm16, ex_last,
        output ex_ready
    );
endinterface

// File: rtl/vdf_stage.sv
// Vector Data Fetch stage: walks a decoded vector instruction element by element, reads the VRF and
// hands operand pairs to EX. Optional macro VDF_SCALAR_BCAST_EN broadcasts RS_VAL as the VT operand for op==VSOP.
module vdf_stage #(
    parameter int          ELEM_W  = 32,
    parameter int          VREG_AW = 3,
    parameter int          IDX_W   = 3,
    parameter int          MAXVL   = 8,
    parameter logic [5:0]  VSOP    = 6'h2A
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [VREG_AW-1:0] ID_VDF_VS_ADD,
    input  logic [VREG_AW-1:0] ID_VDF_VT_ADD,
    input  logic [VREG_AW-1:0] ID_VDF_VD_ADD,
    input  logic [4:0]         ID_VDF_SHAMT,
    input  logic [5:0]         ID_VDF_OP,
    input  logic [5:0]         ID_VDF_FUNC,
    input  logic [15:0]        ID_VDF_IMM16,
    input  logic [IDX_W-1:0]   ID_VDF_INDEX,
    input  logic [ELEM_W-1:0]  ID_EX_RS_VAL,
    input  logic [IDX_W:0]     vl,
    output logic               pipe_stall,
    output logic [VREG_AW-1:0] vrf_vs_add,
    output logic [VREG_AW-1:0] vrf_vt_add,
    output logic [IDX_W-1:0]   vrf_idx,
    input  logic [ELEM_W-1:0]  vrf_vs_data,
    input  logic [ELEM_W-1:0]  vrf_vt_data,
    vdf_stage_if.master        ex_if
);
    localparam int             LW      = IDX_W + 1;
    localparam logic [LW-1:0]  MAXVL_L = LW'(MAXVL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_RESP  = 2'd2,
        S_ISSUE = 2'd3
    } state_e;

    state_e              state_q,  state_d;
    logic                stall_q,  stall_d;
    logic [LW-1:0]       len_q,    len_d;
    logic [IDX_W-1:0]    elem_q,   elem_d;
    logic [VREG_AW-1:0]  vs_add_q, vs_add_d;
    logic [VREG_AW-1:0]  vt_add_q, vt_add_d;
    logic [VREG_AW-1:0]  vd_add_q, vd_add_d;
    logic [4:0]          shamt_q,  shamt_d;
    logic [5:0]          op_q,     op_d;
    logic [5:0]          func_q,   func_d;
    logic [15:0]         imm16_q,  imm16_d;
    logic [ELEM_W-1:0]   rs_val_q, rs_val_d;
    logic                valid_q,  valid_d;
    logic                last_q,   last_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [ELEM_W-1:0]   vs_val_q, vs_val_d;
    logic [ELEM_W-1:0]   vt_val_q, vt_val_d;

    logic [LW-1:0]       len_s;
    logic [ELEM_W-1:0]   vt_sel_s;

    assign len_s = (vl > MAXVL_L) ? MAXVL_L : vl;

`ifdef VDF_SCALAR_BCAST_EN
    assign vt_sel_s = (op_q == VSOP) ? rs_val_q : vrf_vt_data;
`else
    logic unused_bcast_s;
    assign vt_sel_s       = vrf_vt_data;
    assign unused_bcast_s = ^{rs_val_q, VSOP};
`endif

    // The VRF address stays on the latched fields so data is still addressed through the RESP cycle.
    assign vrf_vs_add = vs_add_q;
    assign vrf_vt_add = vt_add_q;
    assign vrf_idx    = elem_q;
    assign pipe_stall = stall_q;

    assign ex_if.ex_valid  = valid_q;
    assign ex_if.ex_last   = last_q;
    assign ex_if.ex_idx    = idx_q;
    assign ex_if.ex_vs_val = vs_val_q;
    assign ex_if.ex_vt_val = vt_val_q;
    assign ex_if.ex_vd_add = vd_add_q;
    assign ex_if.ex_op     = op_q;
    assign ex_if.ex_func   = func_q;
    assign ex_if.ex_shamt  = shamt_q;
    assign ex_if.ex_imm16  = imm16_q;

    // Next-state and output-register logic of the element walker.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        elem_d   = elem_q;
        vs_add_d = vs_add_q;
        vt_add_d = vt_add_q;
        vd_add_d = vd_add_q;
        shamt_d  = shamt_q;
        op_d     = op_q;
        func_d   = func_q;
        imm16_d  = imm16_q;
        rs_val_d = rs_val_q;
        valid_d  = valid_q;
        last_d   = last_q;
        idx_d    = idx_q;
        vs_val_d = vs_val_q;
        vt_val_d = vt_val_q;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (id_valid && !stall_q) begin
                    vs_add_d = ID_VDF_VS_ADD;
                    vt_add_d = ID_VDF_VT_ADD;
                    vd_add_d = ID_VDF_VD_ADD;
                    shamt_d  = ID_VDF_SHAMT;
                    op_d     = ID_VDF_OP;
                    func_d   = ID_VDF_FUNC;
                    imm16_d  = ID_VDF_IMM16;
                    rs_val_d = ID_EX_RS_VAL;
                    elem_d   = ID_VDF_INDEX;
                    len_d    = len_s;
                    // A start index at or beyond the length retires with no transfer.
                    if ({1'b0, ID_VDF_INDEX} < len_s) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                vs_val_d = vrf_vs_data;
                vt_val_d = vt_sel_s;
                idx_d    = elem_q;
                last_d   = ({1'b0, elem_q} == (len_q - LW'(1)));
                valid_d  = 1'b1;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                if (valid_q && ex_if.ex_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        elem_d  = elem_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        stall_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            stall_q  <= 1'b0;
            len_q    <= '0;
            elem_q   <= '0;
            vs_add_q <= '0;
            vt_add_q <= '0;
            vd_add_q <= '0;
            shamt_q  <= 5'd0;
            op_q     <= 6'd0;
            func_q   <= 6'd0;
            imm16_q  <= 16'd0;
            rs_val_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            idx_q    <= '0;
            vs_val_q <= '0;
            vt_val_q <= '0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            len_q    <= len_d;
            elem_q   <= elem_d;
            vs_add_q <= vs_add_d;
            vt_add_q <= vt_add_d;
            vd_add_q <= vd_add_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            func_q   <= func_d;
            imm16_q  <= imm16_d;
            rs_val_q <= rs_val_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            vs_val_q <= vs_val_d;
            vt_val_q <= vt_val_d;
        end
    end
endmodule

// File: tb/tb_vdf_stage.sv
// Self-checking bench for vdf_stage: a vector table plus randomized instructions checked against a
// list-based model of the element walk; honours VDF_SCALAR_BCAST_EN the same way as the design.
module tb_vdf_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [2:0]  vs_add, vt_add, vd_add, index;
    logic [4:0]  shamt;
    logic [5:0]  op, func;
    logic [15:0] imm16;
    logic [31:0] rs_val;
    logic [3:0]  vl;
    logic        pipe_stall;
    logic [2:0]  vrf_vs_add, vrf_vt_add, vrf_idx;
    logic [31:0] vrf_vs_data, vrf_vt_data;
    logic [31:0] vrf_mem [8][8];

    int n_checks = 0;
    int n_fail   = 0;

    vdf_stage_if #(.ELEM_W(32), .VREG_AW(3), .IDX_W(3)) ex_if ();

    vdf_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .ID_VDF_VS_ADD(vs_add), .ID_VDF_VT_ADD(vt_add), .ID_VDF_VD_ADD(vd_add),
        .ID_VDF_SHAMT(shamt), .ID_VDF_OP(op), .ID_VDF_FUNC(func), .ID_VDF_IMM16(imm16),
        .ID_VDF_INDEX(index), .ID_EX_RS_VAL(rs_val), .vl(vl), .pipe_stall(pipe_stall),
        .vrf_vs_add(vrf_vs_add), .vrf_vt_add(vrf_vt_add), .vrf_idx(vrf_idx),
        .vrf_vs_data(vrf_vs_data), .vrf_vt_data(vrf_vt_data), .ex_if(ex_if)
    );

    always #5 clock = ~clock;

    // Register file model with one cycle of read latency.
    always @(posedge clock) begin
        vrf_vs_data <= vrf_mem[vrf_vs_add][vrf_idx];
        vrf_vt_data <= vrf_mem[vrf_vt_add][vrf_idx];
    end

    typedef struct {
        logic [3:0]  vl;
        logic [2:0]  index, vs, vt, vd;
        logic [5:0]  op;
        logic [31:0] rs;
        int          ready_mode;   // 0: always ready, 1: random, 2: stall 4 cycles on idx 6
        logic [3:0]  vl_mid;
        int          exp_pairs;
    } vec_t;

    typedef struct {
        logic [31:0] vs_val;
        logic [31:0] vt_val;
        logic [2:0]  idx;
        logic        last;
    } pair_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_vt(input logic [5:0] o, input logic [31:0] rs,
                                           input logic [2:0] vt, input int i);
`ifdef VDF_SCALAR_BCAST_EN
        if (o == 6'h2A) return rs;
`endif
        return vrf_mem[vt][i];
    endfunction

    task automatic run_instr(input vec_t v, input string tag);
        pair_t       exp_q[$];
        pair_t       p;
        int          len, n, cyc, first_cyc, last_hs, hold_cnt;
        logic        rdy, prev_hold;
        logic [4:0]  x_shamt;
        logic [5:0]  x_func;
        logic [15:0] x_imm;
        logic [127:0] snap, prev_snap;

        len = (v.vl > 4'd8) ? 8 : int'(v.vl);
        for (int i = int'(v.index); i < len; i++) begin
            p.vs_val = vrf_mem[v.vs][i];
            p.vt_val = exp_vt(v.op, v.rs, v.vt, i);
            p.idx    = 3'(i);
            p.last   = (i == len - 1);
            exp_q.push_back(p);
        end
        x_shamt = 5'($urandom);
        x_func  = 6'($urandom);
        x_imm   = 16'($urandom);

        @(negedge clock);
        id_valid = 1'b1; vs_add = v.vs; vt_add = v.vt; vd_add = v.vd; index = v.index;
        op = v.op; rs_val = v.rs; vl = v.vl; shamt = x_shamt; func = x_func; imm16 = x_imm;
        @(posedge clock);
        #1;
        id_valid = 1'b0; vs_add = 3'($urandom); vt_add = 3'($urandom); vd_add = 3'($urandom);
        index = 3'($urandom); op = 6'($urandom); rs_val = $urandom; vl = v.vl_mid;

        n = 0; cyc = 0; first_cyc = -1; last_hs = 0; hold_cnt = 0; prev_hold = 1'b0;
        prev_snap = '0;
        while (n < exp_q.size() && cyc < 400) begin
            @(negedge clock);
            cyc++;
            chk({tag, " stall busy"}, 128'(pipe_stall), 128'(1'b1));
            snap = {ex_if.ex_valid, ex_if.ex_last, ex_if.ex_idx, ex_if.ex_vs_val, ex_if.ex_vt_val,
                    ex_if.ex_vd_add, ex_if.ex_op, ex_if.ex_func, ex_if.ex_shamt, ex_if.ex_imm16};
            if (prev_hold) chk({tag, " hold stable"}, snap, prev_snap);
            if (ex_if.ex_valid && first_cyc < 0) first_cyc = cyc;
            if (v.ready_mode == 1) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else if (v.ready_mode == 2 && ex_if.ex_valid && ex_if.ex_idx == 3'd6 && hold_cnt < 4) begin
                rdy = 1'b0;
                hold_cnt++;
            end else begin
                rdy = 1'b1;
            end
            ex_if.ex_ready = rdy;
            if (ex_if.ex_valid && rdy) begin
                chk({tag, " vs_val"}, 128'(ex_if.ex_vs_val), 128'(exp_q[n].vs_val));
                chk({tag, " vt_val"}, 128'(ex_if.ex_vt_val), 128'(exp_q[n].vt_val));
                chk({tag, " idx"},    128'(ex_if.ex_idx),    128'(exp_q[n].idx));
                chk({tag, " last"},   128'(ex_if.ex_last),   128'(exp_q[n].last));
                chk({tag, " passthru"},
                    128'({ex_if.ex_vd_add, ex_if.ex_op, ex_if.ex_func, ex_if.ex_shamt, ex_if.ex_imm16}),
                    128'({v.vd, v.op, x_func, x_shamt, x_imm}));
                if (v.ready_mode == 0 && n > 0) chk({tag, " gap"}, 128'(cyc - last_hs), 128'(3));
                last_hs = cyc;
                n++;
            end
            prev_hold = ex_if.ex_valid && !rdy;
            prev_snap = snap;
        end
        if (n < exp_q.size()) chk({tag, " timeout pairs"}, 128'(n), 128'(exp_q.size()));
        if (v.ready_mode == 0 && exp_q.size() > 0) chk({tag, " latency"}, 128'(first_cyc), 128'(3));
        if (v.ready_mode == 2) chk({tag, " frozen cycles"}, 128'(hold_cnt), 128'(4));
        chk({tag, " pair count"}, 128'(n), 128'(v.exp_pairs));
        repeat (4) begin
            @(negedge clock);
            chk({tag, " idle valid"}, 128'(ex_if.ex_valid), 128'(1'b0));
            chk({tag, " idle stall"}, 128'(pipe_stall), 128'(1'b0));
            ex_if.ex_ready = 1'b0;
        end
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        int waited;
        for (int r = 0; r < 8; r++)
            for (int e = 0; e < 8; e++) vrf_mem[r][e] = $urandom;

        reset = 1'b0; id_valid = 1'b0; ex_if.ex_ready = 1'b0;
        vs_add = 3'd0; vt_add = 3'd0; vd_add = 3'd0; index = 3'd0; shamt = 5'd0;
        op = 6'd0; func = 6'd0; imm16 = 16'd0; rs_val = 32'd0; vl = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset valid", 128'(ex_if.ex_valid), 128'(1'b0));
        chk("reset stall", 128'(pipe_stall), 128'(1'b0));
        chk("reset last",  128'(ex_if.ex_last), 128'(1'b0));
        chk("reset data",  128'({ex_if.ex_vs_val, ex_if.ex_vt_val, ex_if.ex_idx, vrf_idx, vrf_vs_add}), 128'(0));
        reset = 1'b1;

        // Reset pulse while a pair is stalled in ISSUE.
        @(negedge clock);
        id_valid = 1'b1; vl = 4'd8; index = 3'd0; vs_add = 3'd1; vt_add = 3'd2; op = 6'h11;
        @(posedge clock);
        #1 id_valid = 1'b0;
        waited = 0;
        while (!ex_if.ex_valid && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        chk("pre-reset valid", 128'(ex_if.ex_valid), 128'(1'b1));
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("midreset valid", 128'(ex_if.ex_valid), 128'(1'b0));
        chk("midreset stall", 128'(pipe_stall), 128'(1'b0));
        chk("midreset data",  128'({ex_if.ex_last, ex_if.ex_vs_val, ex_if.ex_op, vrf_idx}), 128'(0));
        reset = 1'b1;
        @(negedge clock);
        chk("post-reset idle", 128'({ex_if.ex_valid, pipe_stall}), 128'(2'b00));

        tbl[0] = '{4'd4,  3'd0, 3'd1, 3'd2, 3'd3, 6'h20, 32'h0,        0, 4'd4, 4};
        tbl[1] = '{4'd8,  3'd5, 3'd3, 3'd4, 3'd5, 6'h21, 32'h1234,     2, 4'd8, 3};
        tbl[2] = '{4'd3,  3'd3, 3'd1, 3'd2, 3'd0, 6'h20, 32'h0,        0, 4'd3, 0};
        tbl[3] = '{4'd0,  3'd0, 3'd1, 3'd2, 3'd0, 6'h20, 32'h0,        0, 4'd0, 0};
        tbl[4] = '{4'd12, 3'd0, 3'd6, 3'd7, 3'd1, 6'h22, 32'h0,        0, 4'd2, 8};
        tbl[5] = '{4'd8,  3'd0, 3'd2, 3'd5, 3'd6, 6'h2A, 32'hDEADBEEF, 1, 4'd8, 8};
        tbl[6] = '{4'd7,  3'd6, 3'd0, 3'd3, 3'd7, 6'h2A, 32'hCAFEF00D, 0, 4'd1, 1};
        tbl[7] = '{4'd15, 3'd7, 3'd4, 3'd1, 3'd2, 6'h05, 32'h0,        0, 4'd9, 1};
        for (int t = 0; t < 8; t++) run_instr(tbl[t], $sformatf("vec%0d", t));

        for (int k = 0; k < 8; k++) begin
            rv.vl = 4'($urandom); rv.index = 3'($urandom); rv.vs = 3'($urandom);
            rv.vt = 3'($urandom); rv.vd = 3'($urandom);
            rv.op = ($urandom_range(0, 1) == 1) ? 6'h2A : 6'($urandom);
            rv.rs = $urandom; rv.ready_mode = 1; rv.vl_mid = 4'($urandom);
            rv.exp_pairs = ((rv.vl > 4'd8 ? 8 : int'(rv.vl)) > int'(rv.index)) ?
                           (rv.vl > 4'd8 ? 8 : int'(rv.vl)) - int'(rv.index) : 0;
            run_instr(rv, $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
